controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port op, input, 6 bits: opcode, instr[31:26] from the datapath instruction register.
REQ-004 The block SHALL have port funct, input, 6 bits: function field, instr[5:0].
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag from the datapath.
REQ-006 The block SHALL have outputs to the datapath: alucontrol (3 bits), alusrca (1), alusrcb (2), iord (1), irwrite (4), memtoreg (1), pcen (1), regdst (1), regwrite (1), pcsource (2).
REQ-007 The block SHALL have port memwrite, output, 1 bit: memory write enable.
REQ-008 The block SHALL have port state, output, 4 bits: current FSM state, for debug.

Function
REQ-009 The FSM states and encodings SHALL be: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13.
REQ-010 The opcodes SHALL be: LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
REQ-011 The fetch transitions SHALL be: FETCH1->FETCH2->FETCH3->FETCH4->DECODE, unconditionally.
REQ-012 DECODE SHALL transition as follows: LB/SB->MEMADR; RTYPE->RTYPEEX; BEQ->BEQEX; J->JEX; ADDI->ADDIEX; any other op->FETCH1.
REQ-013 MEMADR SHALL go to LBRD when op=LB and to SBWR otherwise; LBRD SHALL go to LBWR.
REQ-014 RTYPEEX SHALL go to RTYPEWR; ADDIEX SHALL go to RTYPEWR with regdst forced 0 (ADDI write-back).
REQ-015 LBWR, SBWR, RTYPEWR, BEQEX and JEX SHALL each return to FETCH1.
REQ-016 Every output SHALL default to 0 in every state except where a state below sets it; alucontrol defaults to 010 (add).
REQ-017 In FETCHn (n=1..4) the block SHALL drive irwrite=one-hot bit n-1 (0001, 0010, 0100, 1000), alusrcb=01, pcsource=00, and assert pcwrite.
REQ-018 DECODE SHALL drive alusrcb=11.
REQ-019 MEMADR and ADDIEX SHALL drive alusrca=1 and alusrcb=10.
REQ-020 LBRD SHALL drive iord=1; LBWR SHALL drive regwrite=1 and memtoreg=1; SBWR SHALL drive iord=1 and memwrite=1.
REQ-021 RTYPEEX SHALL drive alusrca=1, alusrcb=00, and alucontrol from funct per REQ-022; RTYPEWR SHALL drive regwrite=1 and regdst=1, except regdst=0 when the previous state was ADDIEX.
REQ-022 The funct decode SHALL be: 100000->010 (add), 100010->110 (sub), 100100->000 (and), 100101->001 (or), 101010->111 (slt); any other funct->010.
REQ-023 BEQEX SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsource=01, and assert branch.
REQ-024 JEX SHALL drive pcsource=10 and assert pcwrite.
REQ-025 pcen SHALL equal pcwrite OR (branch AND zero), combinationally, so zero is sampled in the same cycle as BEQEX.
REQ-026 All outputs except pcen and alucontrol in RTYPEEX SHALL be pure functions of state (Moore), with no registered output delay.
REQ-027 Instruction latency in cycles SHALL be: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6, unknown op 5.
REQ-028 op and funct SHALL be read only in DECODE, MEMADR and RTYPEEX; changes to them in other states SHALL have no effect.

Reset
REQ-029 Asserting reset SHALL force state to FETCH1 immediately, independent of clk, including mid-instruction.
REQ-030 While reset is high, irwrite, pcen, regwrite and memwrite SHALL be 0; the other outputs SHALL hold their FETCH1 values.
REQ-031 On the first rising edge after reset deasserts, FETCH1 outputs SHALL be active (irwrite=0001, pcen=1).

Verification
REQ-032 The bench SHALL check reset: assert reset between edges -> state=0 with no clock edge; irwrite=0000, pcen=0, regwrite=0, memwrite=0.
REQ-033 The bench SHALL check add: op=000000, funct=100000 -> states 0,1,2,3,4,9,10; alucontrol=010 in 9; regwrite=1 and regdst=1 in 10; back to 0.
REQ-034 The bench SHALL check beq: op=000100 in BEQEX with zero=1 -> pcen=1, pcsource=01, alucontrol=110; repeat with zero=0 -> pcen=0.
REQ-035 The bench SHALL check lb/sb: LB -> 8 cycles, memtoreg=1 and regwrite=1 in LBWR; SB -> memwrite=1 and iord=1 for exactly 1 cycle in SBWR.
REQ-036 The bench SHALL check an unknown op: op=111111 -> DECODE->FETCH1 with no regwrite or memwrite pulse.
REQ-037 The bench SHALL check reset mid-instruction: reset in RTYPEEX -> state=0 asynchronously, with no regwrite pulse.

Source files
------------

// File: rtl/controller.sv
// rtl/controller.sv - multicycle MIPS-subset control FSM with byte-wide instruction fetch
// Moore outputs decoded from state; pcen and R-type alucontrol are the only input-dependent outputs.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       pcen,
  output logic       regdst,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       memwrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q;
  state_t next_state;
  logic   from_addi;
  logic   pcwrite;
  logic   branch;
  logic   regwrite_raw;
  logic   memwrite_raw;
  logic [3:0] irwrite_raw;

  // from_addi lets RTYPEWR double as the ADDI write-back state with rt as destination
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH1;
      from_addi <= 1'b0;
    end else begin
      state_q   <= next_state;
      from_addi <= (state_q == ADDIEX);
    end
  end

  always_comb begin
    next_state = FETCH1;
    case (state_q)
      FETCH1:  next_state = FETCH2;
      FETCH2:  next_state = FETCH3;
      FETCH3:  next_state = FETCH4;
      FETCH4:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_J:         next_state = JEX;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = FETCH1;
        endcase
      end
      MEMADR:  next_state = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    next_state = LBWR;
      RTYPEEX: next_state = RTYPEWR;
      ADDIEX:  next_state = RTYPEWR;
      default: next_state = FETCH1;
    endcase
  end

  always_comb begin
    alucontrol   = 3'b010;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    iord         = 1'b0;
    irwrite_raw  = 4'b0000;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite_raw = 1'b0;
    pcsource     = 2'b00;
    memwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      FETCH1: begin irwrite_raw = 4'b0001; alusrcb = 2'b01; pcwrite = 1'b1; end
      FETCH2: begin irwrite_raw = 4'b0010; alusrcb = 2'b01; pcwrite = 1'b1; end
      FETCH3: begin irwrite_raw = 4'b0100; alusrcb = 2'b01; pcwrite = 1'b1; end
      FETCH4: begin irwrite_raw = 4'b1000; alusrcb = 2'b01; pcwrite = 1'b1; end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      LBRD:   iord = 1'b1;
      LBWR:   begin regwrite_raw = 1'b1; memtoreg = 1'b1; end
      SBWR:   begin iord = 1'b1; memwrite_raw = 1'b1; end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      RTYPEWR: begin regwrite_raw = 1'b1; regdst = ~from_addi; end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsource   = 2'b01;
        branch     = 1'b1;
      end
      JEX:    begin pcsource = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
  end

  // write strobes are held off for the whole reset interval, not just until the next edge
  assign irwrite  = reset ? 4'b0000 : irwrite_raw;
  assign regwrite = regwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed self-checking bench for the controller FSM
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic [3:0] irwrite;
  logic       memtoreg;
  logic       pcen;
  logic       regdst;
  logic       regwrite;
  logic [1:0] pcsource;
  logic       memwrite;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [2:0] c_alu  [16];
  logic [1:0] c_asb  [16];
  logic [1:0] c_pcs  [16];
  logic [3:0] c_ir   [16];
  logic       c_asa  [16];
  logic       c_io   [16];
  logic       c_mt   [16];
  logic       c_pcen [16];
  logic       c_rd   [16];
  logic       c_rw   [16];
  logic       c_mw   [16];
  int cnt_rw;
  int cnt_mw;

  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
    .irwrite(irwrite), .memtoreg(memtoreg), .pcen(pcen), .regdst(regdst),
    .regwrite(regwrite), .pcsource(pcsource), .memwrite(memwrite), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks n cycles starting at the current sample point, checking the state
  // sequence (nibble i of seq) and recording outputs per visited state.
  task automatic walk(input string tag, input int n, input logic [31:0] seq);
    int s;
    for (int k = 0; k < 16; k++) begin
      c_alu[k] = 'x; c_asb[k] = 'x; c_pcs[k] = 'x; c_ir[k] = 'x; c_asa[k] = 'x;
      c_io[k] = 'x; c_mt[k] = 'x; c_pcen[k] = 'x; c_rd[k] = 'x; c_rw[k] = 'x; c_mw[k] = 'x;
    end
    cnt_rw = 0;
    cnt_mw = 0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s state[%0d]", tag, i), 32'(state), 32'(seq[i*4 +: 4]));
      s = int'(state);
      c_alu[s] = alucontrol; c_asb[s] = alusrcb; c_pcs[s] = pcsource; c_ir[s] = irwrite;
      c_asa[s] = alusrca; c_io[s] = iord; c_mt[s] = memtoreg; c_pcen[s] = pcen;
      c_rd[s] = regdst; c_rw[s] = regwrite; c_mw[s] = memwrite;
      if (regwrite === 1'b1) cnt_rw++;
      if (memwrite === 1'b1) cnt_mw++;
      @(posedge clk);
      @(negedge clk);
    end
    check($sformatf("%s end state", tag), 32'(state), 32'd0);
  endtask

  localparam logic [31:0] SEQ_R    = 32'h0A943210;
  localparam logic [31:0] SEQ_ADDI = 32'h0AD43210;
  localparam logic [31:0] SEQ_LB   = 32'h76543210;
  localparam logic [31:0] SEQ_SB   = 32'h08543210;
  localparam logic [31:0] SEQ_BEQ  = 32'h00B43210;
  localparam logic [31:0] SEQ_J    = 32'h00C43210;
  localparam logic [31:0] SEQ_UNK  = 32'h00043210;

  logic [5:0] funct_tab [5];
  logic [2:0] alu_tab   [5];

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b0;
    funct_tab[0] = 6'b100010; alu_tab[0] = 3'b110;
    funct_tab[1] = 6'b100100; alu_tab[1] = 3'b000;
    funct_tab[2] = 6'b100101; alu_tab[2] = 3'b001;
    funct_tab[3] = 6'b101010; alu_tab[3] = 3'b111;
    funct_tab[4] = 6'b111111; alu_tab[4] = 3'b010;

    // reset held across edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst state", 32'(state), 32'd0);
    check("rst irwrite", 32'(irwrite), 32'd0);
    check("rst pcen", 32'(pcen), 32'd0);
    check("rst regwrite", 32'(regwrite), 32'd0);
    check("rst memwrite", 32'(memwrite), 32'd0);
    check("rst alusrcb", 32'(alusrcb), 32'b01);
    reset = 1'b0;
    #1;
    check("release irwrite", 32'(irwrite), 32'b0001);
    check("release pcen", 32'(pcen), 32'd1);

    // R-type add
    op = 6'b000000; funct = 6'b100000;
    walk("add", 7, SEQ_R);
    check("add alucontrol", 32'(c_alu[9]), 32'b010);
    check("add ex alusrca", 32'(c_asa[9]), 32'd1);
    check("add ex alusrcb", 32'(c_asb[9]), 32'b00);
    check("add wr regwrite", 32'(c_rw[10]), 32'd1);
    check("add wr regdst", 32'(c_rd[10]), 32'd1);
    check("add regwrite cycles", 32'(cnt_rw), 32'd1);
    check("fetch1 irwrite", 32'(c_ir[0]), 32'b0001);
    check("fetch2 irwrite", 32'(c_ir[1]), 32'b0010);
    check("fetch3 irwrite", 32'(c_ir[2]), 32'b0100);
    check("fetch4 irwrite", 32'(c_ir[3]), 32'b1000);
    check("fetch4 alusrcb", 32'(c_asb[3]), 32'b01);
    check("fetch pcen", 32'(c_pcen[2]), 32'd1);
    check("decode alusrcb", 32'(c_asb[4]), 32'b11);
    check("decode irwrite", 32'(c_ir[4]), 32'b0000);

    // remaining funct codes
    for (int i = 0; i < 5; i++) begin
      funct = funct_tab[i];
      walk($sformatf("funct%0d", i), 7, SEQ_R);
      check($sformatf("funct%0d alucontrol", i), 32'(c_alu[9]), 32'(alu_tab[i]));
    end

    // beq taken / not taken
    op = 6'b000100; zero = 1'b1;
    walk("beq taken", 6, SEQ_BEQ);
    check("beq taken pcen", 32'(c_pcen[11]), 32'd1);
    check("beq pcsource", 32'(c_pcs[11]), 32'b01);
    check("beq alucontrol", 32'(c_alu[11]), 32'b110);
    check("beq regwrite cycles", 32'(cnt_rw), 32'd0);
    zero = 1'b0;
    walk("beq not taken", 6, SEQ_BEQ);
    check("beq not taken pcen", 32'(c_pcen[11]), 32'd0);

    // lb / sb
    op = 6'b100000;
    walk("lb", 8, SEQ_LB);
    check("lb memadr alusrcb", 32'(c_asb[5]), 32'b10);
    check("lb memadr alusrca", 32'(c_asa[5]), 32'd1);
    check("lb rd iord", 32'(c_io[6]), 32'd1);
    check("lb wr memtoreg", 32'(c_mt[7]), 32'd1);
    check("lb wr regwrite", 32'(c_rw[7]), 32'd1);
    check("lb regwrite cycles", 32'(cnt_rw), 32'd1);
    check("lb memwrite cycles", 32'(cnt_mw), 32'd0);
    op = 6'b101000;
    walk("sb", 7, SEQ_SB);
    check("sb memwrite", 32'(c_mw[8]), 32'd1);
    check("sb iord", 32'(c_io[8]), 32'd1);
    check("sb memwrite cycles", 32'(cnt_mw), 32'd1);
    check("sb regwrite cycles", 32'(cnt_rw), 32'd0);

    // addi writes back through RTYPEWR with regdst=0
    op = 6'b001000;
    walk("addi", 7, SEQ_ADDI);
    check("addi ex alusrcb", 32'(c_asb[13]), 32'b10);
    check("addi wr regwrite", 32'(c_rw[10]), 32'd1);
    check("addi wr regdst", 32'(c_rd[10]), 32'd0);

    // jump
    op = 6'b000010;
    walk("j", 6, SEQ_J);
    check("j pcsource", 32'(c_pcs[12]), 32'b10);
    check("j pcen", 32'(c_pcen[12]), 32'd1);

    // unknown op
    op = 6'b111111;
    walk("unknown", 5, SEQ_UNK);
    check("unknown regwrite cycles", 32'(cnt_rw), 32'd0);
    check("unknown memwrite cycles", 32'(cnt_mw), 32'd0);

    // reset asserted mid-instruction, between clock edges
    op = 6'b000000; funct = 6'b100000;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid pre-reset state", 32'(state), 32'd9);
    #2;
    reset = 1'b1;
    #1;
    check("mid async state", 32'(state), 32'd0);
    check("mid irwrite", 32'(irwrite), 32'd0);
    check("mid pcen", 32'(pcen), 32'd0);
    check("mid regwrite", 32'(regwrite), 32'd0);
    check("mid alusrcb", 32'(alusrcb), 32'b01);
    @(posedge clk);
    #1;
    check("mid held state", 32'(state), 32'd0);
    check("mid held regwrite", 32'(regwrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid release irwrite", 32'(irwrite), 32'b0001);
    walk("post reset add", 7, SEQ_R);
    check("post reset regwrite cycles", 32'(cnt_rw), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
